// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } btn_state_e;

endpackage

// File: rtl/sync_ff.sv
// Generic N-flop synchroniser for asynchronous single-bit inputs; synchronous reset to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q, sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronises and debounces btn_raw, emits one btn_pulse per
// qualified press (gated by en) and a registered debounced btn_level.
// Optional auto-repeat while held is built when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic en,
  output logic btn_pulse,
  output logic btn_level
);

  localparam longint unsigned CntLimit = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      64'(DEBOUNCE_CYCLES) >= CntLimit || 64'(REPEAT_DELAY) >= CntLimit ||
      64'(REPEAT_PERIOD) >= CntLimit) begin : gen_param_err
    $error("button_conditioner: illegal parameter combination");
  end

  logic btn_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(btn_raw),
    .q_o(btn_s)
  );

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepDelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RepPeriodLast = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  // Set until the first repeat of the current hold has fired.
  logic             rep_first_q, rep_first_d;
`endif

  // Debounce FSM next-state, counter and output pulse/level decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    // Repeat tracking restarts whenever we are not sitting in HELD.
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DebLast) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          pulse_d = en;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_cnt_q == (rep_first_q ? RepDelayLast : RepPeriodLast)) begin
          pulse_d     = en;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d   = rep_cnt_q + 1'b1;
          rep_first_d = rep_first_q;
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_HELD;
        end else if (cnt_q == DebLast) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: a behavioural model predicts the outputs after
// every clock edge into a queue; a monitor on the falling edge pops and compares.
module tb_button_conditioner;

  localparam int SyncStages = 2;
  localparam int DebCycles  = 4;
  localparam int RepDelay   = 10;
  localparam int RepPeriod  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic en = 1'b0;
  logic btn_pulse, btn_level;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;
  int model_pulses = 0;

  logic [1:0] exp_q[$];  // {pulse, level} expected after each edge

  button_conditioner #(
    .SYNC_STAGES(SyncStages),
    .DEBOUNCE_CYCLES(DebCycles),
    .CNT_W(20),
    .REPEAT_DELAY(RepDelay),
    .REPEAT_PERIOD(RepPeriod)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .en(en),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  // Reference model: the debounced level flips once the synchronised input has disagreed
  // with it for DebCycles+1 consecutive samples; a press pulses if en is high that cycle.
  // With auto-repeat, pulses follow at DelAY, DELAY+PERIOD, ... uninterrupted held samples.
  initial begin : model
    logic dly[$];
    int   run;
    int   streak;
    logic lvl;
    logic s, p;
    for (int i = 0; i < SyncStages; i++) dly.push_back(1'b0);
    run = 0; streak = 0; lvl = 1'b0;
    forever begin
      @(posedge clk);
      p = 1'b0;
      if (rst) begin
        dly.delete();
        for (int i = 0; i < SyncStages; i++) dly.push_back(1'b0);
        run = 0; streak = 0; lvl = 1'b0;
      end else begin
        s = dly.pop_front();
        dly.push_back(btn_raw);
        if (s != lvl) begin
          run++;
          if (run == DebCycles + 1) begin
            lvl = s;
            run = 0;
            streak = 0;
            if (s) p = en;
          end
        end else begin
          if (lvl) begin
            if (run > 0) begin
              streak = 0;  // bounce back into the held state restarts the hold time
            end else begin
              streak++;
`ifdef BTN_AUTOREPEAT_EN
              if (streak >= RepDelay && ((streak - RepDelay) % RepPeriod) == 0) p = en;
`endif
            end
          end
          run = 0;
        end
      end
      if (p) model_pulses++;
      exp_q.push_back({p, lvl});
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  initial begin : monitor
    logic [1:0] e;
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (btn_pulse) dut_pulses++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (btn_pulse !== e[1]) begin
          errors++;
          $display("FAIL pulse cycle %0d: got %b want %b", cyc, btn_pulse, e[1]);
        end
        checks++;
        if (btn_level !== e[0]) begin
          errors++;
          $display("FAIL level cycle %0d: got %b want %b", cyc, btn_level, e[0]);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic rs, input int n);
    btn_raw = r;
    en      = e;
    rst     = rs;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_count(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin : stim
    int base;
    int len;
    logic r;
    // Reset held with the button pressed.
    drive(1'b1, 1'b1, 1'b1, 3);
    drive(1'b0, 1'b1, 1'b0, 12);

    // Clean press and release.
    base = dut_pulses;
    drive(1'b1, 1'b1, 1'b0, 12);
    drive(1'b0, 1'b1, 1'b0, 12);
    check_count("clean_press_pulses", dut_pulses - base, 1);

    // Too-short press.
    base = dut_pulses;
    drive(1'b1, 1'b1, 1'b0, 3);
    drive(1'b0, 1'b1, 1'b0, 12);
    check_count("short_press_pulses", dut_pulses - base, 0);

    // en low at qualification, raised later while still held.
    base = dut_pulses;
    drive(1'b1, 1'b0, 1'b0, 8);
    drive(1'b1, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 1'b0, 12);
    check_count("en_low_pulses", dut_pulses - base, 0);

    // Held with a one-cycle glitch low, then full release.
    base = dut_pulses;
    drive(1'b1, 1'b1, 1'b0, 10);
    drive(1'b0, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 1'b0, 6);
    drive(1'b0, 1'b1, 1'b0, 12);
    check_count("glitch_pulses", dut_pulses - base, 1);

    // Long hold, reset mid-hold, then a fresh press from the still-held button.
    drive(1'b1, 1'b1, 1'b0, 21);
    drive(1'b1, 1'b1, 1'b1, 1);
    drive(1'b1, 1'b1, 1'b0, 30);
    drive(1'b0, 1'b1, 1'b0, 12);

    // Randomised bouncing, holds, en toggling and occasional resets.
    r = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r = ~r;
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
      drive(r, ($urandom_range(0, 3) != 0), 1'b0, len);
      if ($urandom_range(0, 39) == 0) drive(r, 1'b1, 1'b1, 1);
    end
    drive(1'b0, 1'b1, 1'b0, 12);
    repeat (3) @(negedge clk);

    check_count("total_pulses", dut_pulses, model_pulses);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
